snn_layer_scheduler: RTL
========================

Name: snn_layer_scheduler

Overview:
- Sequences the shared combinational neuron datapath through one fully-connected layer for one timestep.
- The datapath takes weight, v_mem_in, beta, function_sel and v_th, and returns spike and v_mem_out.
- For each output neuron: loads v_mem from the membrane memory, accumulates the weight of every spiking input, runs one leak/fire step, writes v_mem back and records the output spike.
- Sits between the Wishbone config registers, the weight SRAM and the v_mem SRAM.

Parameters:
- N_IN, 16, number of layer inputs (≥2).
- N_OUT, 8, number of output neurons (≥1).
- W, 8, weight / v_mem / beta / v_th width.
- WADDR_W, $clog2(N_IN*N_OUT), weight memory address width.
- VADDR_W, $clog2(N_OUT), v_mem memory address width.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- start_i  in  1  begin one timestep; honoured only in IDLE.
- spikes_in_i  in  N_IN  input spike vector; snapshotted on an accepted start.
- beta_i  in  W  leak factor; snapshotted on an accepted start.
- v_th_i  in  W  threshold; snapshotted on an accepted start.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of timestep.
- spikes_out_o  out  N_OUT  output spike vector; registered.
- w_addr_o  out  WADDR_W  weight read address, = j*N_IN+i.
- w_re_o  out  1  weight read strobe.
- w_rdata_i  in  W  weight data, valid the cycle after w_re_o.
- v_addr_o  out  VADDR_W  v_mem address, read and write.
- v_re_o  out  1  v_mem read strobe.
- v_we_o  out  1  v_mem write strobe.
- v_rdata_i  in  W  v_mem data, valid the cycle after v_re_o.
- v_wdata_o  out  W  v_mem write data.
- n_weight_o  out  W  to neuron weight.
- n_v_mem_o  out  W  to neuron v_mem_in.
- n_beta_o  out  W  to neuron beta.
- n_v_th_o  out  W  to neuron v_th.
- n_func_sel_o  out  1  to neuron function_sel: 0 = accumulate, 1 = leak/fire.
- n_spike_i  in  1  from neuron spike.
- n_v_mem_i  in  W  from neuron v_mem_out.

Behaviour:
- Reset: state = IDLE.
  - All outputs 0, including spikes_out_o.
  - Internal acc, i, j and config snapshot regs all 0.
- Reset mid-operation: abandons the timestep on the next edge with no further SRAM writes. v_mem entries already written keep their new values.
- Registered state; combinational strobes, addresses and datapath drives decoded from state and counters. Registers: acc (W), i (input index), j (output index), spk_snap (N_IN), beta_r, vth_r.
- n_beta_o = beta_r and n_v_th_o = vth_r in all states.
- Unless stated otherwise: n_weight_o = 0, n_func_sel_o = 0, n_v_mem_o = acc.
- IDLE:
  - If start_i: snapshot spikes_in_i, beta_i and v_th_i; clear spikes_out_o; set j = 0; go to VLOAD.
  - start_i while busy_o is ignored.
- VLOAD: v_re_o = 1, v_addr_o = j → VLATCH.
- VLATCH: acc ← v_rdata_i; i ← 0 → SCAN.
- SCAN:
  - If spk_snap[i]: w_re_o = 1, w_addr_o = j*N_IN+i → WACC.
  - Else if i == N_IN-1 → FIRE.
  - Else i ← i+1, stay in SCAN.
- WACC:
  - n_weight_o = w_rdata_i, n_func_sel_o = 0, n_v_mem_o = acc; acc ← n_v_mem_i.
  - If i == N_IN-1 → FIRE; else i ← i+1 → SCAN.
- FIRE:
  - n_func_sel_o = 1, n_weight_o = 0, n_v_mem_o = acc.
  - v_we_o = 1, v_addr_o = j, v_wdata_o = n_v_mem_i; spikes_out_o[j] ← n_spike_i.
  - If j == N_OUT-1 → DONE; else j ← j+1 → VLOAD.
- DONE: done_o = 1 for exactly one cycle → IDLE. spikes_out_o holds until the next accepted start.
- Arithmetic: none in the scheduler. Saturation and leak belong to the neuron; acc only stores the neuron result.
- Latency: busy cycles from the first VLOAD to the last FIRE = N_OUT*(N_IN+3) + total spiking inputs × N_OUT. DONE follows immediately.
- Zero input spikes: no w_re_o pulses at all; each neuron still leaks and fires.
- Counters never wrap: i and j are bounded by N_IN-1 and N_OUT-1.
- w_re_o, v_re_o and v_we_o are mutually exclusive in every cycle.

Test Plan:
- Stub neuron for all scenarios: sel 0 → v_mem_out = v+w; sel 1 → spike = (v ≥ v_th), v_mem_out = spike ? 0 : v. Parameters N_IN = 4, N_OUT = 2.
- Scenario 1: reset, then idle → all outputs 0; busy_o = 0; no memory strobes.
- Scenario 2: spikes_in = 4'b0000, v_mem = {5, 9}, v_th = 8 → no w_re_o pulses; done_o exactly 15 cycles after start (14 busy + DONE); v_mem written {5, 0}; spikes_out = 2'b10.
- Scenario 3: spikes_in = 4'b0101, weights w[j*4+i] = 1..8, v_mem = {0, 0}, v_th = 10 → reads at addresses 0, 2, 4, 6; sums {4, 12}; writes {4, 0}; spikes_out = 2'b10; 18 busy cycles.
- Scenario 4: start_i held high through an entire run → exactly one timestep; second run begins only on the cycle after DONE, with a fresh snapshot.
- Scenario 5: wb_rst_i asserted during the second neuron's SCAN → next cycle is IDLE, all outputs 0; only v_mem[0] was written.
- Scenario 6: spikes_in changed mid-run → the result matches the snapshot taken at start, not the new vector.

Source files
------------

// File: rtl/snn_layer_scheduler.sv
// Layer scheduler: walks the shared neuron datapath over every (output, input) pair
// of one fully-connected layer for a single timestep, driving weight and v_mem SRAMs.
module snn_layer_scheduler #(
  parameter int N_IN    = 16,
  parameter int N_OUT   = 8,
  parameter int W       = 8,
  parameter int WADDR_W = $clog2(N_IN * N_OUT),
  parameter int VADDR_W = $clog2(N_OUT)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic [N_IN-1:0]    spikes_in_i,
  input  logic [W-1:0]       beta_i,
  input  logic [W-1:0]       v_th_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_OUT-1:0]   spikes_out_o,
  output logic [WADDR_W-1:0] w_addr_o,
  output logic               w_re_o,
  input  logic [W-1:0]       w_rdata_i,
  output logic [VADDR_W-1:0] v_addr_o,
  output logic               v_re_o,
  output logic               v_we_o,
  input  logic [W-1:0]       v_rdata_i,
  output logic [W-1:0]       v_wdata_o,
  output logic [W-1:0]       n_weight_o,
  output logic [W-1:0]       n_v_mem_o,
  output logic [W-1:0]       n_beta_o,
  output logic [W-1:0]       n_v_th_o,
  output logic               n_func_sel_o,
  input  logic               n_spike_i,
  input  logic [W-1:0]       n_v_mem_i
);
  // state  | meaning
  // IDLE   | waiting for start, snapshot inputs on accept
  // VLOAD  | issue v_mem read for neuron j
  // VLATCH | capture v_mem into acc, reset input index
  // SCAN   | look for next spiking input, issue weight read if found
  // WACC   | accumulate returned weight through the neuron
  // FIRE   | leak/fire, write v_mem back, record spike
  // DONE   | one-cycle completion pulse

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  typedef enum logic [2:0] {IDLE, VLOAD, VLATCH, SCAN, WACC, FIRE, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   acc;
  logic [IW-1:0]  i_idx;
  logic [JW-1:0]  j_idx;
  logic [N_IN-1:0] spk_snap;
  logic [W-1:0]   beta_r, vth_r;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      acc          <= '0;
      i_idx        <= '0;
      j_idx        <= '0;
      spk_snap     <= '0;
      beta_r       <= '0;
      vth_r        <= '0;
      spikes_out_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start_i) begin
          spk_snap     <= spikes_in_i;
          beta_r       <= beta_i;
          vth_r        <= v_th_i;
          spikes_out_o <= '0;
          j_idx        <= '0;
        end
        VLATCH: begin
          acc   <= v_rdata_i;
          i_idx <= '0;
        end
        SCAN: if (!spk_snap[i_idx] && i_idx != I_LAST) i_idx <= i_idx + 1'b1;
        WACC: begin
          acc <= n_v_mem_i;
          if (i_idx != I_LAST) i_idx <= i_idx + 1'b1;
        end
        FIRE: begin
          spikes_out_o[j_idx] <= n_spike_i;
          if (j_idx != J_LAST) j_idx <= j_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    busy_o       = (state != IDLE);
    done_o       = 1'b0;
    w_re_o       = 1'b0;
    w_addr_o     = '0;
    v_re_o       = 1'b0;
    v_we_o       = 1'b0;
    v_addr_o     = '0;
    v_wdata_o    = '0;
    n_weight_o   = '0;
    n_v_mem_o    = acc;
    n_beta_o     = beta_r;
    n_v_th_o     = vth_r;
    n_func_sel_o = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = VLOAD;
      VLOAD: begin
        v_re_o    = 1'b1;
        v_addr_o  = VADDR_W'(j_idx);
        state_nxt = VLATCH;
      end
      VLATCH: state_nxt = SCAN;
      SCAN: begin
        if (spk_snap[i_idx]) begin
          w_re_o    = 1'b1;
          w_addr_o  = WADDR_W'(32'(j_idx) * N_IN + 32'(i_idx));
          state_nxt = WACC;
        end else if (i_idx == I_LAST) begin
          state_nxt = FIRE;
        end
      end
      WACC: begin
        n_weight_o = w_rdata_i;
        state_nxt  = (i_idx == I_LAST) ? FIRE : SCAN;
      end
      FIRE: begin
        n_func_sel_o = 1'b1;
        v_we_o       = 1'b1;
        v_addr_o     = VADDR_W'(j_idx);
        v_wdata_o    = n_v_mem_i;
        state_nxt    = (j_idx == J_LAST) ? DONE : VLOAD;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
